// File: rtl/spi_sckgen.sv
// SPI serial-clock engine: generates a burst of N SCK cycles with programmable
// half-period divider, CPOL and CPHA, plus per-edge drive/sample strobes.
module spi_sckgen #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sck,
    output logic             sck_rise,
    output logic             sck_fall,
    output logic             drive,
    output logic             sample,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [LEN_W:0]   r_e;
    logic [DIV_W-1:0] r_div_q;
    logic [LEN_W-1:0] r_len_q;
    logic             r_cpol_q;
    logic             r_cpha_q;
    logic             r_sck;
    logic             r_done;

    logic w_run;
    logic w_edge;
    logic w_last;
    logic w_first;
    logic w_lead;

    // Abort suppresses every strobe in the cycle it is seen.
    assign w_run   = (r_state == RUN) && !abort;
    assign w_edge  = w_run && (r_cnt == r_div_q);
    assign w_last  = (r_e == {r_len_q, 1'b1});
    assign w_first = w_run && (r_cnt == '0) && (r_e == '0);
    assign w_lead  = ~r_e[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_e      <= '0;
            r_div_q  <= '0;
            r_len_q  <= '0;
            r_cpol_q <= 1'b0;
            r_cpha_q <= 1'b0;
            r_sck    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sck <= cpol;
                    if (start) begin
                        r_div_q  <= div;
                        r_len_q  <= len;
                        r_cpol_q <= cpol;
                        r_cpha_q <= cpha;
                        r_cnt    <= '0;
                        r_e      <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_sck   <= r_cpol_q;
                        r_cnt   <= '0;
                        r_e     <= '0;
                    end else if (r_cnt == r_div_q) begin
                        r_cnt <= '0;
                        r_sck <= ~r_sck;
                        if (w_last) begin
                            r_e     <= '0;
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_e <= r_e + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sck_rise = w_edge && !r_sck;
        sck_fall = w_edge && r_sck;
        drive    = 1'b0;
        sample   = 1'b0;
        if (!r_cpha_q) begin
            drive  = w_first || (w_edge && !w_lead && !w_last);
            sample = w_edge && w_lead;
        end else begin
            drive  = w_edge && w_lead;
            sample = w_edge && !w_lead;
        end
    end

    assign sck  = r_sck;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule

// File: tb/tb_spi_sckgen.sv
// Randomised and directed bench for spi_sckgen against an arithmetic burst model.
module tb_spi_sckgen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] div;
    logic [4:0] len;
    logic       cpol;
    logic       cpha;
    logic       sck;
    logic       sck_rise;
    logic       sck_fall;
    logic       drive;
    logic       sample;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    spi_sckgen #(.DIV_W(8), .LEN_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .div(div), .len(len), .cpol(cpol), .cpha(cpha),
        .sck(sck), .sck_rise(sck_rise), .sck_fall(sck_fall),
        .drive(drive), .sample(sample), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic a, input logic b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", nm, cyc, a, b);
        end
    endtask

    task automatic lit(input string nm, input int a, input int b);
        checks++;
        if (a != b) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, a, b);
        end
    endtask

    // Behavioural model: burst timing derived from the start cycle by arithmetic.
    int m_known = 0;
    int m_run   = 0;
    int m_T, m_div, m_len;
    bit m_cpol, m_cpha, m_sck_idle, m_done;

    always @(negedge clk) begin
        bit e_busy, e_sck, e_rise, e_fall, e_drive, e_sample, e_done, edge_now, last_now;
        int rel, P, N, k;
        e_busy = 0; e_sck = 0; e_rise = 0; e_fall = 0; e_drive = 0; e_sample = 0;
        e_done = 0; edge_now = 0; last_now = 0;
        if (m_run != 0) begin
            rel = cyc - m_T - 1;
            P = m_div + 1;
            N = m_len + 1;
            e_busy = 1;
            e_sck = m_cpol ^ (((rel / P) % 2) == 1);
            edge_now = ((rel + 1) % P) == 0;
            k = (rel + 1) / P - 1;
            last_now = edge_now && (k == 2 * N - 1);
            if (!abort) begin
                if (edge_now) begin
                    e_rise = !e_sck;
                    e_fall = e_sck;
                    if (!m_cpha) begin
                        e_sample = (k % 2) == 0;
                        e_drive  = ((k % 2) == 1) && !last_now;
                    end else begin
                        e_drive  = (k % 2) == 0;
                        e_sample = (k % 2) == 1;
                    end
                end
                if (!m_cpha && rel == 0) e_drive = 1;
            end
        end else begin
            e_sck  = m_sck_idle;
            e_done = m_done;
        end
        if (m_known != 0) begin
            chk("busy", busy, e_busy);
            chk("sck", sck, e_sck);
            chk("sck_rise", sck_rise, e_rise);
            chk("sck_fall", sck_fall, e_fall);
            chk("drive", drive, e_drive);
            chk("sample", sample, e_sample);
            chk("done", done, e_done);
        end
        if (rst) begin
            m_known = 1; m_run = 0; m_sck_idle = 0; m_done = 0;
        end else if (m_run != 0) begin
            m_done = 0;
            if (abort) begin
                m_run = 0; m_sck_idle = m_cpol;
            end else if (last_now) begin
                m_run = 0; m_sck_idle = m_cpol; m_done = 1;
            end
        end else begin
            m_done = 0;
            m_sck_idle = cpol;
            if (start) begin
                m_run = 1; m_T = cyc; m_div = int'(div); m_len = int'(len);
                m_cpol = cpol; m_cpha = cpha;
            end
        end
    end

    // Per-burst observation, indexed by cycles after the start cycle.
    bit sck_h [0:16400];
    bit busy_h[0:16400];
    int o_rise, o_fall, o_drive, o_sample, o_ndone, o_post, o_coinc_bad;
    int o_first_rise, o_first_fall, o_first_drive, o_first_sample, o_done1, o_done2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_obs(input int ncyc, input bit hold, input int chg_at, input int abort_at);
        o_rise = 0; o_fall = 0; o_drive = 0; o_sample = 0; o_ndone = 0; o_post = 0;
        o_coinc_bad = 0; o_first_rise = -1; o_first_fall = -1; o_first_drive = -1;
        o_first_sample = -1; o_done1 = -1; o_done2 = -1;
        for (int i = 1; i <= ncyc; i++) begin
            step();
            start = hold;
            abort = (i == abort_at);
            if (i == chg_at) begin
                div = 8'd5; len = 5'd10; cpol = ~cpol; cpha = ~cpha;
            end
            #1;
            sck_h[i] = sck;
            busy_h[i] = busy;
            if (sck_rise) begin o_rise++; if (o_first_rise < 0) o_first_rise = i; end
            if (sck_fall) begin o_fall++; if (o_first_fall < 0) o_first_fall = i; end
            if (drive) begin o_drive++; if (o_first_drive < 0) o_first_drive = i; end
            if (sample) begin o_sample++; if (o_first_sample < 0) o_first_sample = i; end
            if (done) begin
                o_ndone++;
                if (o_done1 < 0) o_done1 = i;
                else if (o_done2 < 0) o_done2 = i;
            end
            if (sample !== sck_rise) o_coinc_bad++;
            if (abort_at > 0 && i >= abort_at && (sck_rise || sck_fall || drive || sample)) o_post++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            start = 0; abort = 0;
        end
    endtask

    task automatic kick(input bit p, input bit h, input int d, input int l);
        cpol = p; cpha = h; div = 8'(d); len = 5'(l);
        idle(3);
        step();
        start = 1;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; div = 8'd3; len = 5'd7; cpol = 0; cpha = 0;
        repeat (3) step();
        rst = 0;
        #1;
        lit("reset_sck", int'(sck), 0);
        lit("reset_busy", int'(busy), 0);
        lit("reset_done", int'(done), 0);

        // CPOL=0 CPHA=0 div=3 len=7
        kick(0, 0, 3, 7);
        run_obs(70, 0, 0, 0);
        lit("t1_first_rise", o_first_rise, 4);
        lit("t1_edges", o_rise + o_fall, 16);
        lit("t1_rises", o_rise, 8);
        lit("t1_done", o_done1, 65);
        lit("t1_drives", o_drive, 8);
        lit("t1_first_drive", o_first_drive, 1);
        lit("t1_samples", o_sample, 8);
        lit("t1_sample_on_rise", o_coinc_bad, 0);

        // CPOL=1 CPHA=1 div=0 len=0
        kick(1, 1, 0, 0);
        lit("t2_idle_sck", int'(sck), 1);
        run_obs(6, 0, 0, 0);
        lit("t2_first_fall", o_first_fall, 1);
        lit("t2_first_drive", o_first_drive, 1);
        lit("t2_first_rise", o_first_rise, 2);
        lit("t2_first_sample", o_first_sample, 2);
        lit("t2_done", o_done1, 3);
        lit("t2_sck_end", int'(sck_h[3]), 1);
        lit("t2_drives", o_drive, 1);

        // back-to-back with start held high
        kick(0, 0, 1, 1);
        run_obs(20, 1, 0, 0);
        lit("t3_done1", o_done1, 9);
        lit("t3_done2", o_done2, 18);
        lit("t3_busy_before", int'(busy_h[8]), 1);
        lit("t3_busy_gap", int'(busy_h[9]), 0);
        lit("t3_busy_after", int'(busy_h[10]), 1);
        idle(20);

        // abort after edge 5; cpol input flipped during the burst
        kick(1, 0, 2, 7);
        run_obs(40, 0, 3, 19);
        lit("t4_edges", o_rise + o_fall, 6);
        lit("t4_post_strobes", o_post, 0);
        lit("t4_no_done", o_ndone, 0);
        lit("t4_busy", int'(busy_h[20]), 0);
        lit("t4_sck_latched", int'(sck_h[20]), 1);
        lit("t4_sck_new", int'(sck_h[21]), 0);

        // reconfiguration during RUN
        kick(0, 1, 1, 3);
        run_obs(25, 0, 3, 0);
        lit("t5_done", o_done1, 17);
        lit("t5_edges", o_rise + o_fall, 8);
        lit("t5_drives", o_drive, 4);
        lit("t5_samples", o_sample, 4);
        lit("t5_sck_done", int'(sck_h[17]), 0);
        lit("t5_sck_newpol", int'(sck_h[18]), 1);

        // maximum length and divider
        kick(0, 0, 255, 31);
        run_obs(16390, 0, 0, 0);
        lit("t6_done", o_done1, 16385);
        lit("t6_edges", o_rise + o_fall, 64);
        lit("t6_drives", o_drive, 32);
        lit("t6_samples", o_sample, 32);
        lit("t6_busy_last", int'(busy_h[16384]), 1);

        // randomised traffic including aborts and resets
        for (int i = 0; i < 6000; i++) begin
            step();
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            div   = 8'($urandom_range(0, 3));
            len   = 5'($urandom_range(0, 31));
            cpol  = 1'($urandom_range(0, 1));
            cpha  = 1'($urandom_range(0, 1));
        end
        step();
        rst = 0; start = 0; abort = 0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
